// File: rtl/if_fetch_ctrl_pkg.sv
// if_fetch_ctrl_pkg: shared widths, reset address and fetch FSM encoding
package if_fetch_ctrl_pkg;
  localparam int XLEN_DEF = 64;
  localparam logic [63:0] PC_RESET_ADDR = 64'h8000_0000;
  localparam int INST_LEN = 32;
  typedef enum logic [2:0] {
    IF_ST_IDLE  = 3'd0,
    IF_ST_REQ   = 3'd1,
    IF_ST_WAIT  = 3'd2,
    IF_ST_HOLD  = 3'd3,
    IF_ST_DRAIN = 3'd4
  } if_st_e;
endpackage

// File: rtl/if_fetch_ctrl_reg.sv
// if_fetch_ctrl_reg: plain register with asynchronous active-low reset to a fixed value
module if_fetch_ctrl_reg #(
  parameter int W = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // capture next value every cycle; reset forces the fixed value
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= RST;
    else q <= d;
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: one-outstanding instruction fetch sequencer with redirects (optional IF_FETCH_FAULT_EN)
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(PC_RESET_ADDR)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_valid_i,
  input  logic [XLEN-1:0]     clint_pc_i,
  input  logic                clint_pc_valid_i,
  input  logic [XLEN-1:0]     branch_pc_i,
  input  logic                branch_pc_valid_i,
  output logic                if_req_valid_o,
  output logic [XLEN-1:0]     if_req_addr_o,
  input  logic                if_req_ready_i,
  input  logic                if_rsp_valid_i,
  input  logic [INST_LEN-1:0] if_rsp_data_i,
  input  logic                if_rsp_err_i,
  output logic                inst_valid_o,
  output logic [INST_LEN-1:0] inst_o,
  output logic [XLEN-1:0]     inst_pc_o,
  output logic                inst_err_o,
  input  logic                inst_ready_i
);
`ifdef IF_FETCH_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif
  if_st_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, redir_pc_q, redir_pc_d, inst_pc_q, inst_pc_d, tgt;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic redir_q, redir_d, inst_err_q, inst_err_d, redir, rsp_err;
  assign redir = flush_valid_i | clint_pc_valid_i | branch_pc_valid_i;
  assign tgt = flush_valid_i ? RESET_PC : clint_pc_valid_i ? clint_pc_i : branch_pc_i;
  assign rsp_err = FAULT_EN & if_rsp_err_i;
  // FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IF_ST_IDLE;
    else state_q <= state_d;
  // next state, pc/redirect bookkeeping and output capture
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    redir_pc_d = redir_pc_q;
    redir_d = redir_q;
    inst_d = inst_q;
    inst_pc_d = inst_pc_q;
    inst_err_d = inst_err_q;
    case (state_q)
      IF_ST_IDLE: begin
        state_d = IF_ST_REQ;
        pc_d = redir ? tgt : pc_q;
      end
      IF_ST_REQ: begin
        redir_pc_d = redir ? tgt : redir_pc_q;
        redir_d = redir | redir_q;
        if (if_req_ready_i) state_d = (redir || redir_q) ? IF_ST_DRAIN : IF_ST_WAIT;
      end
      IF_ST_WAIT: begin
        if (if_rsp_valid_i && redir) begin
          pc_d = tgt;
          state_d = IF_ST_REQ;
        end else if (if_rsp_valid_i) begin
          inst_d = if_rsp_data_i;
          inst_pc_d = pc_q;
          inst_err_d = rsp_err;
          state_d = IF_ST_HOLD;
        end else if (redir) begin
          redir_pc_d = tgt;
          redir_d = 1'b1;
          state_d = IF_ST_DRAIN;
        end
      end
      IF_ST_HOLD: begin
        if (redir || inst_ready_i) begin
          pc_d = redir ? tgt : pc_q + XLEN'(4);
          state_d = IF_ST_REQ;
        end
      end
      IF_ST_DRAIN: begin
        if (if_rsp_valid_i) begin
          pc_d = redir ? tgt : redir_pc_q;
          redir_d = 1'b0;
          state_d = IF_ST_REQ;
        end else begin
          redir_pc_d = redir ? tgt : redir_pc_q;
        end
      end
      default: state_d = IF_ST_IDLE;
    endcase
`ifdef IF_FETCH_FAULT_EN
    if (state_d == IF_ST_REQ && state_q != IF_ST_REQ && pc_d[1:0] != 2'b00) begin
      state_d = IF_ST_HOLD;
      inst_d = '0;
      inst_pc_d = pc_d;
      inst_err_d = 1'b1;
    end
`endif
  end
  if_fetch_ctrl_reg #(.W(XLEN), .RST(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .d(pc_d), .q(pc_q)
  );
  if_fetch_ctrl_reg #(.W(XLEN + 1), .RST('0)) u_redir (
    .clk(clk), .rst(rst), .d({redir_d, redir_pc_d}), .q({redir_q, redir_pc_q})
  );
  if_fetch_ctrl_reg #(.W(XLEN + INST_LEN + 1), .RST('0)) u_out (
    .clk(clk), .rst(rst), .d({inst_err_d, inst_d, inst_pc_d}), .q({inst_err_q, inst_q, inst_pc_q})
  );
  assign if_req_valid_o = state_q == IF_ST_REQ;
  assign if_req_addr_o = FAULT_EN ? pc_q : {pc_q[XLEN-1:2], 2'b00};
  assign inst_valid_o = state_q == IF_ST_HOLD;
  assign inst_o = inst_q;
  assign inst_pc_o = inst_pc_q;
  assign inst_err_o = inst_err_q;
endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer between the PC logic and the instruction-memory port. Owns the fetch PC and issues one instruction read at a time over a valid/ready request channel. Applies trap, branch and flush redirects, discarding any response that became stale. Delivers each fetched instruction with its PC to the decode stage over a valid/ready handshake.

## Interface
- `XLEN`, default 64: PC/address width.
- `RESET_PC`, default `PC_RESET_ADDR` (0x8000_0000): first fetch address after reset and target of flush.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `flush_valid_i` in 1: redirect to `RESET_PC`; highest priority.
- `clint_pc_i` in XLEN: trap target, from mem stage.
- `clint_pc_valid_i` in 1: trap redirect request; second priority.
- `branch_pc_i` in XLEN: branch target, from exc stage.
- `branch_pc_valid_i` in 1: branch redirect request; lowest priority.
- `if_req_valid_o` out 1: fetch request valid.
- `if_req_addr_o` out XLEN: fetch address.
- `if_req_ready_i` in 1: memory accepts request.
- `if_rsp_valid_i` in 1: response valid; always accepted, one per accepted request.
- `if_rsp_data_i` in 32: instruction word.
- `if_rsp_err_i` in 1: bus error on this response.
- `inst_valid_o` out 1: instruction available to decode.
- `inst_o` out 32: instruction.
- `inst_pc_o` out XLEN: PC of `inst_o`.
- `inst_err_o` out 1: fetch fault flag; constant 0 without `IF_FETCH_FAULT_EN`.
- `inst_ready_i` in 1: decode accepts instruction.

## Operation
- Redirect: any valid input in a cycle; target is `RESET_PC`, `clint_pc_i` or `branch_pc_i`, by the priority above.
- FSM states: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE: state on reset; always goes to REQ on the next cycle.
- REQ: `if_req_valid_o`=1, `if_req_addr_o`=pc.
  - Valid and address stay stable until `if_req_ready_i`; a request is never withdrawn.
  - Accept with no redirect, current or pending: go to WAIT.
  - Redirect before or on acceptance: latch target into `redir_pc_q`, set `redir_q`. Go to DRAIN on acceptance, else stay in REQ with the address unchanged.
- WAIT: on `if_rsp_valid_i` with no redirect, capture data/err/pc into output registers and go to HOLD.
  - Redirect in the same cycle as the response: drop the response, pc=target, go to REQ.
  - Redirect without a response: latch target, go to DRAIN.
- DRAIN: discard the response.
  - On `if_rsp_valid_i`: pc=`redir_pc_q`, clear `redir_q`, go to REQ.
  - A further redirect while in DRAIN overwrites `redir_pc_q`; newest wins.
  - A redirect coinciding with the response uses the new target directly.
- HOLD: `inst_valid_o`=1.
  - On `inst_ready_i`: pc=pc+4, go to REQ.
  - Redirect, with or without ready: instruction is dropped (not consumed), pc=target, go to REQ.
- PC arithmetic: modulo 2^XLEN; 0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
- Reset mid-transaction: FSM returns to IDLE immediately and any outstanding response is ignored. The memory side must also be reset.

## Timing
- Reset values: `if_req_valid_o`=0, `if_req_addr_o`=RESET_PC, `inst_valid_o`=0, `inst_o`=0, `inst_pc_o`=0, `inst_err_o`=0, pc=RESET_PC, `redir_q`=0.
- First `if_req_valid_o` is asserted in the 2nd cycle after `rst` deasserts.
- Latency: request accepted in cycle T, response in T+k (k≥1), `inst_valid_o` in T+k+1.
- Next request: the cycle after the decode handshake.
- Throughput: one instruction per 3 cycles minimum (k=1, ready always high).
- Redirect cost with nothing outstanding: new address appears on `if_req_addr_o` the next cycle.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- `IF_FETCH_FAULT_EN` defined:
  - If pc[1:0]≠0 on entering REQ, skip the memory request: go directly to HOLD with `inst_err_o`=1 and `inst_o`=0.
  - `if_rsp_err_i` is propagated to `inst_err_o`.
- Not defined: `if_rsp_err_i` is ignored, `inst_err_o` is tied to 0, and `if_req_addr_o` has bits [1:0] forced to 0.

## Structure
- Shared header `sysconfig.v` holds `XLEN`/`XLEN_BUS`, `PC_RESET_ADDR`, `INST_LEN`=32, and the FSM state encodings `IF_ST_IDLE..IF_ST_DRAIN` (3-bit).
- One sub-module: `regTemplate`, for the pc, redirect and output registers. It must be given an active-low async-reset variant, since this block uses that reset.

## Test plan
- Reset release, `if_req_ready_i`=1, response k=1 with data 0x00000013, `inst_ready_i`=1 -> requests at 0x80000000, 0x80000004, 0x80000008; `inst_valid_o` every 3rd cycle with the matching `inst_pc_o`.
- Branch to 0x80000100 while in WAIT, response arrives 2 cycles later -> response discarded, no `inst_valid_o`, next request at 0x80000100.
- `clint_pc_valid_i` (0x80001000) and `branch_pc_valid_i` (0x80000200) asserted together in HOLD -> held instruction dropped, next request at 0x80001000.
- `if_req_ready_i` held low for 5 cycles, branch asserted in cycle 2 -> address stays 0x80000000 until acceptance, then DRAIN, then request at the branch target.
- `inst_ready_i` low for 4 cycles in HOLD -> `inst_o`/`inst_pc_o` stable, no new request; pc advances by 4 on release.
- With `IF_FETCH_FAULT_EN`: branch to 0x80000102 -> no memory request, `inst_valid_o`=1 with `inst_err_o`=1 and `inst_pc_o`=0x80000102. Response with `if_rsp_err_i`=1 -> `inst_err_o`=1.
